// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package muldiv_pkg;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIXUP,
    S_DONE
  } state_t;

  function automatic logic op_is_div(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the mul/div sequencer.
// Latency: n/a (wires only).
// Backpressure: requester watches busy; start while busy is dropped.
interface muldiv_if #(parameter int WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srca, srcb, mthi, mtlo, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, mthi, mtlo, wd,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One shift-add (multiply) or restoring-subtract (divide) iteration.
// Latency: combinational.
// Backpressure: none; the sequencer decides when to register the result.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             add_cin;
  logic [WIDTH+1:0] add_res;
  logic [WIDTH:0]   mul_sum;
  logic             keep;

  // Single WIDTH+1 bit adder; subtract is a + ~b + 1 and its carry-out means no borrow.
  always_comb begin
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    add_a   = {1'b0, acc_hi};
    add_b   = {1'b0, operand};
    add_cin = 1'b0;
    if (div_mode) begin
      add_a   = shifted;
      add_b   = ~{1'b0, operand};
      add_cin = 1'b1;
    end
    add_res = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};

    // Multiply: low multiplier bit gates the add, then the whole pair shifts right.
    mul_sum = acc_lo[0] ? add_res[WIDTH:0] : {1'b0, acc_hi};
    // Divide: partial remainder stays below the divisor, so it fits back into WIDTH bits.
    keep    = add_res[WIDTH+1];

    if (div_mode) begin
      nxt_hi = keep ? add_res[WIDTH-1:0] : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], keep};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
// Latency: start edge -> done visible after WIDTH+2 further edges (PREP, WIDTH x ITER, FIXUP).
// Backpressure: busy high in PREP/ITER/FIXUP; start, mthi and mtlo are ignored while busy.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  state_t             state_nxt;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] prod_neg;
  logic [CW-1:0]      count;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;
  logic               is_div;
  logic               use_abs;
  logic               last_iter;

  // Divide by zero runs on raw operands so the remainder comes out as the original dividend.
  assign is_div    = op_is_div(op_q);
  assign use_abs   = op_is_signed(op_q) && !(is_div && div_zero);
  assign abs_a     = (use_abs && sign_a) ? -a_q : a_q;
  assign abs_b     = (use_abs && sign_b) ? -b_q : b_q;
  assign last_iter = (count == CW'(WIDTH - 1));

  assign bus.busy = (state == S_PREP) || (state == S_ITER) || (state == S_FIXUP);
  assign bus.done = (state == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (is_div),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .operand  (opnd),
    .nxt_hi   (step_hi),
    .nxt_lo   (step_lo)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: fixed PREP -> WIDTH x ITER -> FIXUP -> DONE walk, restartable from DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_PREP;
      S_PREP:  state_nxt = S_ITER;
      S_ITER:  if (last_iter) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_DONE;
      S_DONE:  state_nxt = bus.start ? S_PREP : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sign correction of the unsigned magnitude result for MULT/DIV.
  always_comb begin
    res_hi   = acc_hi;
    res_lo   = acc_lo;
    prod_neg = -{acc_hi, acc_lo};
    if (op_q == OP_MULT && (sign_a ^ sign_b)) begin
      {res_hi, res_lo} = prod_neg;
    end else if (op_q == OP_DIV && !div_zero) begin
      if (sign_a ^ sign_b) res_lo = -acc_lo;
      if (sign_a)          res_hi = -acc_hi;
    end
  end

  // Operand latch, iteration datapath and HI/LO write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      count    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            op_q     <= op_t'(bus.op);
            a_q      <= bus.srca;
            b_q      <= bus.srcb;
            sign_a   <= bus.srca[WIDTH-1];
            sign_b   <= bus.srcb[WIDTH-1];
            div_zero <= (bus.srcb == '0);
          end
          if (bus.mthi) hi_q <= bus.wd;
          if (bus.mtlo) lo_q <= bus.wd;
        end
        S_PREP: begin
          acc_hi <= '0;
          acc_lo <= is_div ? abs_a : abs_b;
          opnd   <= is_div ? abs_b : abs_a;
          count  <= '0;
        end
        S_ITER: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + 1'b1;
        end
        S_FIXUP: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized ops vs a reference model.
// Latency: expects done after 34 edges following the start edge.
// Backpressure: exercises start/mthi/mtlo while busy and in the DONE cycle.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_if #(.WIDTH(32)) bus();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    u  = '0;
    case (op)
      2'b00: u = sa * sb;
      2'b01: u = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) u = {a, 32'hFFFFFFFF};
        else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          u = {r[31:0], q[31:0]};
        end else u = {a % b, a / b};
      end
    endcase
    return u;
  endfunction

  // Drive a start at the current (negedge) time; returns at the negedge after the start edge.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.srca = a; bus.srcb = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts edges and busy cycles until done; returns at the negedge of the DONE cycle.
  task automatic wait_done(output int lat, output int bcyc, output bit tmo);
    lat = 0; bcyc = 0; tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy) bcyc++;
      if (bus.done) begin tmo = 1'b0; break; end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcyc, output bit tmo);
    @(negedge clk);
    launch(op, a, b);
    wait_done(lat, bcyc, tmo);
  endtask

  task automatic test_reset;
    bus.start = 0; bus.op = 0; bus.srca = 0; bus.srcb = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.wd = 0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #10;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", bus.done); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL reset hi: got %h want 0", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL reset lo: got %h want 0", bus.lo); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_multu_max;
    int lat, bc; bit tmo;
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL multu timeout: got no done, want done"); end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL multu latency: got %0d edges want 34", lat); end
    n_cmp++; if (bc !== 34) begin n_bad++; $display("FAIL multu busy cycles: got %0d want 34", bc); end
    n_cmp++; if (bus.hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu hi: got %h want fffffffe", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h00000001) begin n_bad++; $display("FAIL multu lo: got %h want 00000001", bus.lo); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done width: got %b want 0", bus.done); end
  endtask

  task automatic test_signed;
    int lat, bc; bit tmo;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, lat, bc, tmo);
    n_cmp++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFF1) begin n_bad++; $display("FAIL mult -3*5: got %h_%h want ffffffff_fffffff1", bus.hi, bus.lo); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bc, tmo);
    n_cmp++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_bad++; $display("FAIL div -7/2: got %h_%h want ffffffff_fffffffd", bus.hi, bus.lo); end
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bc, tmo);
    n_cmp++; if ({bus.hi, bus.lo} !== 64'h00000002_0000000E) begin n_bad++; $display("FAIL divu 100/7: got %h_%h want 00000002_0000000e", bus.hi, bus.lo); end
  endtask

  task automatic test_corners;
    int lat, bc; bit tmo;
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc, tmo);
    n_cmp++; if ({bus.hi, bus.lo} !== 64'h00000000_80000000) begin n_bad++; $display("FAIL div overflow: got %h_%h want 00000000_80000000", bus.hi, bus.lo); end
    run_op(OP_DIVU, 32'h1234, 32'h0, lat, bc, tmo);
    n_cmp++; if ({bus.hi, bus.lo} !== 64'h00001234_FFFFFFFF) begin n_bad++; $display("FAIL divu by 0: got %h_%h want 00001234_ffffffff", bus.hi, bus.lo); end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL div0 latency: got %0d want 34", lat); end
    run_op(OP_DIV, 32'hFFFFFF00, 32'h0, lat, bc, tmo);
    n_cmp++; if ({bus.hi, bus.lo} !== 64'hFFFFFF00_FFFFFFFF) begin n_bad++; $display("FAIL div neg by 0: got %h_%h want ffffff00_ffffffff", bus.hi, bus.lo); end
  endtask

  task automatic test_ignore;
    int lat, bc; bit tmo;
    logic [31:0] a, b, hi_before;
    logic [63:0] exp;
    a = $urandom; b = $urandom;
    exp = model(OP_MULT, a, b);
    @(negedge clk);
    hi_before = bus.hi;
    launch(OP_MULT, a, b);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.srca = 32'h1234; bus.srcb = 32'd7;
    bus.mthi = 1'b1; bus.wd = 32'h0000DEAD;
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0;
    n_cmp++; if (bus.hi !== hi_before) begin n_bad++; $display("FAIL mthi while busy: got %h want %h", bus.hi, hi_before); end
    wait_done(lat, bc, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL ignore timeout: got no done, want done"); end
    n_cmp++; if ({bus.hi, bus.lo} !== exp) begin n_bad++; $display("FAIL ignore result: got %h_%h want %h", bus.hi, bus.lo, exp); end
    bus.mtlo = 1'b1; bus.wd = 32'h0000BEEF;
    @(negedge clk);
    bus.mtlo = 1'b0;
    n_cmp++; if (bus.lo !== 32'h0000BEEF) begin n_bad++; $display("FAIL mtlo in done: got %h want 0000beef", bus.lo); end
    n_cmp++; if (bus.hi !== exp[63:32]) begin n_bad++; $display("FAIL hi after mtlo: got %h want %h", bus.hi, exp[63:32]); end
  endtask

  task automatic test_back_to_back;
    int lat, bc; bit tmo;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bc, tmo);
    n_cmp++; if ({bus.hi, bus.lo} !== 64'h00000002_0000000E) begin n_bad++; $display("FAIL b2b first: got %h_%h want 00000002_0000000e", bus.hi, bus.lo); end
    launch(OP_MULT, 32'hFFFFFFFD, 32'd5);
    wait_done(lat, bc, tmo);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL b2b latency: got %0d want 34", lat); end
    n_cmp++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFF1) begin n_bad++; $display("FAIL b2b second: got %h_%h want ffffffff_fffffff1", bus.hi, bus.lo); end
  endtask

  task automatic test_random;
    int lat, bc; bit tmo;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = $urandom_range(1, 9);
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: a = $urandom_range(0, 1000);
        default: ;
      endcase
      exp = model(op, a, b);
      run_op(op, a, b, lat, bc, tmo);
      n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL rand[%0d] latency: got %0d want 34", i, lat); end
      n_cmp++; if (bus.hi !== exp[63:32]) begin n_bad++; $display("FAIL rand[%0d] op%0d %h,%h hi: got %h want %h", i, op, a, b, bus.hi, exp[63:32]); end
      n_cmp++; if (bus.lo !== exp[31:0]) begin n_bad++; $display("FAIL rand[%0d] op%0d %h,%h lo: got %h want %h", i, op, a, b, bus.lo, exp[31:0]); end
    end
  endtask

  task automatic test_reset_mid;
    bit saw_done, saw_busy;
    @(negedge clk);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wd = 32'hA5A5A5A5;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    launch(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
    repeat (16) @(posedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL busy before abort: got %b want 1", bus.busy); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort done: got %b want 0", bus.done); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL abort hi: got %h want 0", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL abort lo: got %h want 0", bus.lo); end
    #3 reset = 1'b0;
    saw_done = 1'b0; saw_busy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
      if (bus.busy) saw_busy = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL done after abort: got %b want 0", saw_done); end
    n_cmp++; if (saw_busy !== 1'b0) begin n_bad++; $display("FAIL busy after abort: got %b want 0", saw_busy); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_corners();
    test_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
